// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch front end for a MIPS-style pipeline. Holds the program
// counter, drives the ROM byte address, selects the next PC and captures the
// ROM word into the IF/ID pipeline register. The hazard unit can stall it or
// redirect it with a branch or jump.
//
// Optional build macro: PC_FETCH_ADDR_FAULT_EN
//   When defined, every next-PC value is range and alignment checked against
//   the ROM window [RESET_PC, RESET_PC + 4*MEMORY_DEPTH). A bad address
//   freezes the unit in HALT with a sticky Fault_o until reset.
//   When undefined, Fault_o is tied low and HALT does not exist.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous active-high reset
//   Stall_i             in   hold PC and IF/ID
//   Branch_i            in   taken-branch redirect (resolved in ID)
//   BranchTarget_i      in   branch target byte address
//   Jump_i              in   J/JAL redirect (resolved in ID)
//   JumpIndex_i         in   instr[25:0] of the jump
//   Instruction_i       in   ROM word at PC_o (combinational ROM)
//   PC_o                out  current PC, ROM byte address
//   IFID_Instruction_o  out  registered instruction
//   IFID_PCPlus4_o      out  registered PC+4 of that instruction
//   IFID_Valid_o        out  IF/ID holds a real instruction
//   Fault_o             out  sticky fetch-address fault
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Branch_i,
  input  logic [DATA_WIDTH-1:0] BranchTarget_i,
  input  logic                  Jump_i,
  input  logic [25:0]           JumpIndex_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4_o,
  output logic                  IFID_Valid_o,
  output logic                  Fault_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1
`ifdef PC_FETCH_ADDR_FAULT_EN
    ,
    S_HALT = 2'd2
`endif
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] ifid_instr_q;
  logic [DATA_WIDTH-1:0] ifid_pcplus4_q;
  logic                  ifid_valid_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  redirect;

  // Next-PC selection: jump beats branch beats stall beats sequential.
  // The jump keeps the upper nibble of the jump instruction's own PC+4,
  // which is what sits in IF/ID while the jump is resolved in ID.
  always_comb begin
    pc_plus4    = pc_q + DATA_WIDTH'(4);
    jump_target = {ifid_pcplus4_q[DATA_WIDTH-1:28], JumpIndex_i, 2'b00};
    redirect    = Jump_i | Branch_i;
    if (Jump_i) begin
      pc_d = jump_target;
    end else if (Branch_i) begin
      pc_d = BranchTarget_i;
    end else if (Stall_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4;
    end
  end

`ifdef PC_FETCH_ADDR_FAULT_EN
  // Window limit computed one bit wider so a window touching the top of
  // the address space does not wrap.
  localparam logic [DATA_WIDTH:0] PC_LIMIT =
    {1'b0, RESET_PC} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  logic fault_q;
  logic addr_fault;

  always_comb begin
    addr_fault = (pc_d[1:0] != 2'b00)
              || ({1'b0, pc_d} < {1'b0, RESET_PC})
              || ({1'b0, pc_d} >= PC_LIMIT);
  end

  assign Fault_o = fault_q;
`else
  assign Fault_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_BOOT;
      pc_q           <= RESET_PC;
      ifid_instr_q   <= '0;
      ifid_pcplus4_q <= '0;
      ifid_valid_q   <= 1'b0;
`ifdef PC_FETCH_ADDR_FAULT_EN
      fault_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
`ifdef PC_FETCH_ADDR_FAULT_EN
        // Frozen until reset; all requests are ignored.
        S_HALT: begin
          state_q <= S_HALT;
        end
`endif
        default: begin
`ifdef PC_FETCH_ADDR_FAULT_EN
          if (addr_fault) begin
            // Keep the last good PC so the offending fetch is never issued.
            fault_q        <= 1'b1;
            ifid_instr_q   <= '0;
            ifid_pcplus4_q <= '0;
            ifid_valid_q   <= 1'b0;
            state_q        <= S_HALT;
          end else
`endif
          begin
            pc_q <= pc_d;
            if (redirect) begin
              // No delay slot: the wrong-path fetch is squashed even when
              // the pipeline is stalled.
              ifid_instr_q   <= '0;
              ifid_pcplus4_q <= '0;
              ifid_valid_q   <= 1'b0;
              state_q        <= S_RUN;
            end else if (Stall_i) begin
              // IF/ID holds; a stall during BOOT stays in BOOT.
              state_q <= state_q;
            end else begin
              ifid_instr_q   <= Instruction_i;
              ifid_pcplus4_q <= pc_plus4;
              ifid_valid_q   <= 1'b1;
              state_q        <= S_RUN;
            end
          end
        end
      endcase
    end
  end

  assign PC_o               = pc_q;
  assign IFID_Instruction_o = ifid_instr_q;
  assign IFID_PCPlus4_o     = ifid_pcplus4_q;
  assign IFID_Valid_o       = ifid_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. A small combinational ROM returns
// 32'hA500_0000 | word_index for addresses inside the 64-word text window
// and 0 elsewhere. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        Stall_i;
  logic        Branch_i;
  logic [31:0] BranchTarget_i;
  logic        Jump_i;
  logic [25:0] JumpIndex_i;
  logic [31:0] Instruction_i;
  logic [31:0] PC_o;
  logic [31:0] IFID_Instruction_o;
  logic [31:0] IFID_PCPlus4_o;
  logic        IFID_Valid_o;
  logic        Fault_o;

  int n_tests;
  int n_fail;

  pc_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .Stall_i            (Stall_i),
    .Branch_i           (Branch_i),
    .BranchTarget_i     (BranchTarget_i),
    .Jump_i             (Jump_i),
    .JumpIndex_i        (JumpIndex_i),
    .Instruction_i      (Instruction_i),
    .PC_o               (PC_o),
    .IFID_Instruction_o (IFID_Instruction_o),
    .IFID_PCPlus4_o     (IFID_PCPlus4_o),
    .IFID_Valid_o       (IFID_Valid_o),
    .Fault_o            (Fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model.
  always_comb begin
    Instruction_i = 32'h0;
    if (PC_o >= 32'h0040_0000 && PC_o < 32'h0040_0100)
      Instruction_i = 32'hA500_0000 | ((PC_o - 32'h0040_0000) >> 2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Stall_i        = 1'b0;
    Branch_i       = 1'b0;
    Jump_i         = 1'b0;
    BranchTarget_i = 32'h0;
    JumpIndex_i    = 26'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle();

    // Reset state
    #2;
    check("rst_pc",    PC_o,               32'h0040_0000);
    check("rst_instr", IFID_Instruction_o, 32'h0);
    check("rst_pc4",   IFID_PCPlus4_o,     32'h0);
    check("rst_valid", {31'h0, IFID_Valid_o}, 32'h0);
    check("rst_fault", {31'h0, Fault_o},   32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("boot_valid0", {31'h0, IFID_Valid_o}, 32'h0);

    // Sequential fetch out of BOOT
    tick();
    check("seq1_pc",    PC_o,               32'h0040_0004);
    check("seq1_valid", {31'h0, IFID_Valid_o}, 32'h1);
    check("seq1_pc4",   IFID_PCPlus4_o,     32'h0040_0004);
    check("seq1_instr", IFID_Instruction_o, 32'hA500_0000);
    tick();
    check("seq2_pc",    PC_o,               32'h0040_0008);
    check("seq2_instr", IFID_Instruction_o, 32'hA500_0001);

    // Stall for three edges at 0x00400008
    Stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    PC_o,               32'h0040_0008);
      check("stall_instr", IFID_Instruction_o, 32'hA500_0001);
      check("stall_pc4",   IFID_PCPlus4_o,     32'h0040_0008);
      check("stall_valid", {31'h0, IFID_Valid_o}, 32'h1);
    end
    Stall_i = 1'b0;
    tick();
    check("resume_pc",    PC_o,               32'h0040_000C);
    check("resume_instr", IFID_Instruction_o, 32'hA500_0002);
    check("resume_pc4",   IFID_PCPlus4_o,     32'h0040_000C);

    // Branch together with stall: redirect wins and flushes
    Stall_i        = 1'b1;
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_0020;
    tick();
    idle();
    check("br_stall_pc",    PC_o,               32'h0040_0020);
    check("br_stall_valid", {31'h0, IFID_Valid_o}, 32'h0);
    check("br_stall_instr", IFID_Instruction_o, 32'h0);
    check("br_stall_pc4",   IFID_PCPlus4_o,     32'h0);
    tick();
    check("br_next_pc",    PC_o,               32'h0040_0024);
    check("br_next_instr", IFID_Instruction_o, 32'hA500_0008);
    check("br_next_valid", {31'h0, IFID_Valid_o}, 32'h1);

    // Position IF/ID PC+4 at 0x00400010, then jump and branch together
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_000C;
    tick();
    idle();
    tick();
    check("pre_jmp_pc4", IFID_PCPlus4_o, 32'h0040_0010);
    Jump_i         = 1'b1;
    JumpIndex_i    = 26'h010_0004;
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_0040;
    tick();
    idle();
    check("jmp_wins_pc",    PC_o, 32'h0040_0010);
    check("jmp_wins_valid", {31'h0, IFID_Valid_o}, 32'h0);

    // Asynchronous reset between edges while PC = 0x00400040
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_003C;
    tick();
    idle();
    tick();
    check("pre_arst_pc",    PC_o, 32'h0040_0040);
    check("pre_arst_valid", {31'h0, IFID_Valid_o}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc",    PC_o, 32'h0040_0000);
    check("arst_valid", {31'h0, IFID_Valid_o}, 32'h0);
    check("arst_instr", IFID_Instruction_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_arst_pc", PC_o, 32'h0040_0004);

`ifndef PC_FETCH_ADDR_FAULT_EN
    // PC+4 wraps modulo 2^32
    Branch_i       = 1'b1;
    BranchTarget_i = 32'hFFFF_FFFC;
    tick();
    idle();
    check("wrap_top_pc", PC_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc",    PC_o,           32'h0);
    check("wrap_pc4",   IFID_PCPlus4_o, 32'h0);
    check("wrap_valid", {31'h0, IFID_Valid_o}, 32'h1);
    check("nofault",    {31'h0, Fault_o}, 32'h0);
`else
    // Last word of the window is legal
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_00FC;
    tick();
    idle();
    check("edge_ok_pc",    PC_o, 32'h0040_00FC);
    check("edge_ok_fault", {31'h0, Fault_o}, 32'h0);

    // Misaligned target
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_0102;
    tick();
    idle();
    check("mis_fault", {31'h0, Fault_o}, 32'h1);
    check("mis_pc",    PC_o, 32'h0040_0004);
    check("mis_valid", {31'h0, IFID_Valid_o}, 32'h0);
    Jump_i      = 1'b1;
    JumpIndex_i = 26'h010_0008;
    tick();
    idle();
    check("halt_jmp_pc",    PC_o, 32'h0040_0004);
    check("halt_jmp_fault", {31'h0, Fault_o}, 32'h1);
    tick();
    check("halt_seq_pc", PC_o, 32'h0040_0004);

    // Reset clears the fault; then an out-of-window target
    reset = 1'b1;
    #1;
    check("fault_clr", {31'h0, Fault_o}, 32'h0);
    check("fault_clr_pc", PC_o, 32'h0040_0000);
    @(negedge clk);
    reset = 1'b0;
    tick();
    Branch_i       = 1'b1;
    BranchTarget_i = 32'h0040_0100;
    tick();
    idle();
    check("oor_fault", {31'h0, Fault_o}, 32'h1);
    check("oor_pc",    PC_o, 32'h0040_0004);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end directly upstream of the program ROM.
- Holds the MIPS program counter and drives the ROM byte address.
- Computes next-PC (sequential, branch, jump) and captures the ROM instruction into the IF/ID pipeline register.
- Handles stall and flush requests from the hazard unit.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction.
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text segment base).
- MEMORY_DEPTH, 64, ROM depth in words; used only by the optional fault check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Stall_i  input  1  hold PC and IF/ID contents.
- Branch_i  input  1  taken-branch redirect (resolved in ID).
- BranchTarget_i  input  DATA_WIDTH  branch byte address.
- Jump_i  input  1  J/JAL redirect (resolved in ID).
- JumpIndex_i  input  26  instr[25:0] of the jump.
- Instruction_i  input  DATA_WIDTH  instruction from ROM for PC_o.
- PC_o  output  DATA_WIDTH  current PC, wired to ROM address.
- IFID_Instruction_o  output  DATA_WIDTH  registered instruction.
- IFID_PCPlus4_o  output  DATA_WIDTH  registered PC+4 of that instruction.
- IFID_Valid_o  output  1  IF/ID holds a real instruction.
- Fault_o  output  1  fetch fault flag (only meaningful with ADDR_FAULT_EN).

Behaviour:
- Reset (asynchronous) values:
  - PC_o = RESET_PC
  - IFID_Instruction_o = 0 (NOP)
  - IFID_PCPlus4_o = 0
  - IFID_Valid_o = 0
  - Fault_o = 0
  - state = BOOT
- ROM is combinational: Instruction_i corresponds to PC_o in the same cycle. Fetch-to-IF/ID latency is 1 cycle.
- Jump target = {IFID_PCPlus4_o[31:28], JumpIndex_i, 2'b00}.
- Next-PC priority, highest first:
  1. Jump_i -> jump target
  2. Branch_i -> BranchTarget_i
  3. Stall_i -> PC_o unchanged
  4. otherwise -> PC_o + 4
- PC+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirect (Jump_i or Branch_i), also when Stall_i is high:
  - PC loads the target.
  - IF/ID is flushed: instruction = 0, valid = 0, PCPlus4 = 0. The wrong-path instruction is discarded; there is no delay slot.
- Stall_i alone: IF/ID holds all fields, PC holds.
- Normal advance: IF/ID captures Instruction_i and PC_o+4; valid = 1.
- States:
  - BOOT: first edge after reset is released. Captures the instruction at RESET_PC normally, then goes to RUN. Stall_i in BOOT holds in BOOT.
  - RUN: normal operation as above.
  - HALT: exists only with ADDR_FAULT_EN, see below.
- Reset asserted mid-operation returns to BOOT/RESET_PC immediately, without waiting for a clock edge.
- Simultaneous Jump_i and Branch_i: jump wins; no error.

Optional Feature:
- Macro: PC_FETCH_ADDR_FAULT_EN.
- With the macro defined, a fault is detected on the next-PC value when either:
  - next-PC[1:0] != 0, or
  - next-PC < RESET_PC, or
  - next-PC >= RESET_PC + 4*MEMORY_DEPTH.
- On a fault:
  - PC is not updated.
  - IF/ID is flushed to invalid.
  - Fault_o goes high on the same edge and is sticky.
  - The state machine enters HALT.
- HALT holds everything and ignores Stall_i, Branch_i and Jump_i; only reset exits it.
- Without the macro: no check, Fault_o tied 0, HALT state absent.

Test Plan:
- Reset release, no stall -> PC_o sequence 0x00400000, 0x00400004, 0x00400008. IFID_Valid_o is 0 in the first cycle, then 1. IFID_PCPlus4_o = 0x00400004 after the first edge.
- Stall_i high for 3 cycles at PC 0x00400008 -> PC_o and IF/ID are unchanged for 3 edges, then fetch resumes at 0x0040000C.
- Branch_i=1 with BranchTarget_i=0x00400020, at the same time as Stall_i=1 -> next PC_o = 0x00400020 and IFID_Valid_o = 0. The following edge captures rom word 8 with valid = 1.
- Jump_i=1 and Branch_i=1 together, IFID_PCPlus4_o=0x00400010, JumpIndex_i=0x0100004 -> PC_o = 0x00400010 (jump wins).
- Reset asserted between clock edges while PC = 0x00400040 -> PC_o = 0x00400000 and IFID_Valid_o = 0 immediately, with no clock edge.
- With PC_FETCH_ADDR_FAULT_EN: BranchTarget_i = 0x00400102, then separately 0x00400100 with MEMORY_DEPTH=64 -> Fault_o = 1 and PC is held in each case. A subsequent Jump_i is ignored; only reset clears the fault.
